ldst_ctrl: RTL and testbench

LDST_CTRL -- requirements
Module: ldst_ctrl

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/ldst_ctrl_if.sv | 36 +++
 rtl/signExtend9.sv | 14 +
 rtl/ldst_ctrl.sv | 143 ++++++++++++++
 tb/tb_ldst_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned IMM_W   = 9;
    localparam int unsigned FAULT_W = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } lsuState_e;

    localparam logic [FAULT_W-1:0] FAULT_NONE     = 2'b00;
    localparam logic [FAULT_W-1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [FAULT_W-1:0] FAULT_TIMEOUT  = 2'b10;

    // Request payload captured when start is accepted.
    typedef struct packed {
        logic              isLoad;
        logic [DATA_W-1:0] base;
        logic [IMM_W-1:0]  imm9;
        logic [DATA_W-1:0] storeData;
    } lsuReq_t;

endpackage

// File: rtl/ldst_ctrl_if.sv
// Request, memory and result signals of the load/store controller.
interface ldst_ctrl_if;
    import lsu_pkg::*;

    logic               start;
    logic               is_load;
    logic [DATA_W-1:0]  base;
    logic [IMM_W-1:0]   imm9;
    logic [DATA_W-1:0]  store_data;
    logic               ready_in;

    logic               mem_req;
    logic               mem_we;
    logic [DATA_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               mem_ready;
    logic [DATA_W-1:0]  mem_rdata;

    logic               done;
    logic               wb_en;
    logic [DATA_W-1:0]  load_data;
    logic               fault;
    logic [FAULT_W-1:0] fault_code;

    modport slave (
        input  start, is_load, base, imm9, store_data, mem_ready, mem_rdata,
        output ready_in, mem_req, mem_we, mem_addr, mem_wdata,
               done, wb_en, load_data, fault, fault_code
    );

    modport master (
        output start, is_load, base, imm9, store_data, mem_ready, mem_rdata,
        input  ready_in, mem_req, mem_we, mem_addr, mem_wdata,
               done, wb_en, load_data, fault, fault_code
    );
endinterface

// File: rtl/signExtend9.sv
// Sign-extends the 9-bit byte offset to the datapath width.
module signExtend9
    import lsu_pkg::*;
(
    input  logic [IMM_W-1:0]  imm9,
    output logic [DATA_W-1:0] immExt_c
);

    // Replicate the offset sign bit into the upper bits.
    always_comb begin
        immExt_c = {{(DATA_W-IMM_W){imm9[IMM_W-1]}}, imm9};
    end

endmodule

// File: rtl/ldst_ctrl.sv
// Single-outstanding LDUR/STUR controller: address generation, alignment
// check, memory handshake with a bounded wait, one-cycle completion pulse.
module ldst_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    ldst_ctrl_if.slave  bus
);

    lsuState_e          state, stateNext;
    lsuReq_t            reqQ, reqNext;
    logic [CNT_W-1:0]   cnt, cntNext;

    logic [DATA_W-1:0]  immExt_c;
    logic [DATA_W-1:0]  addrSum_c;

    logic               readyNext;
    logic               memReqNext, memWeNext;
    logic [DATA_W-1:0]  memAddrNext, memWdataNext, loadDataNext;
    logic               doneNext, wbEnNext, faultNext;
    logic [FAULT_W-1:0] faultCodeNext;

    signExtend9 uSext (
        .imm9     (reqQ.imm9),
        .immExt_c (immExt_c)
    );

    // Effective address, modulo 2^64.
    always_comb begin
        addrSum_c = reqQ.base + immExt_c;
    end

    // Next state and next values of every registered output.
    always_comb begin
        stateNext     = state;
        reqNext       = reqQ;
        cntNext       = cnt;
        memReqNext    = 1'b0;
        memWeNext     = 1'b0;
        memAddrNext   = bus.mem_addr;
        memWdataNext  = bus.mem_wdata;
        loadDataNext  = bus.load_data;
        doneNext      = 1'b0;
        wbEnNext      = 1'b0;
        faultNext     = bus.fault;
        faultCodeNext = bus.fault_code;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    reqNext.isLoad    = bus.is_load;
                    reqNext.base      = bus.base;
                    reqNext.imm9      = bus.imm9;
                    reqNext.storeData = bus.store_data;
                    cntNext           = '0;
                    faultNext         = 1'b0;
                    faultCodeNext     = FAULT_NONE;
                    stateNext         = ADDR;
                end
            end
            ADDR: begin
                memAddrNext = addrSum_c;
                if (addrSum_c[2:0] != 3'b000) begin
                    faultNext     = 1'b1;
                    faultCodeNext = FAULT_MISALIGN;
                    doneNext      = 1'b1;
                    stateNext     = DONE;
                end else begin
                    memReqNext   = 1'b1;
                    memWeNext    = !reqQ.isLoad;
                    memWdataNext = reqQ.storeData;
                    stateNext    = REQ;
                end
            end
            REQ: begin
                // A ready on the final allowed cycle still wins over the timeout.
                if (bus.mem_ready) begin
                    doneNext  = 1'b1;
                    wbEnNext  = reqQ.isLoad;
                    if (reqQ.isLoad) begin
                        loadDataNext = bus.mem_rdata;
                    end
                    stateNext = DONE;
                end else if (cnt + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
                    cntNext       = cnt + CNT_W'(1);
                    faultNext     = 1'b1;
                    faultCodeNext = FAULT_TIMEOUT;
                    doneNext      = 1'b1;
                    stateNext     = DONE;
                end else begin
                    cntNext    = cnt + CNT_W'(1);
                    memReqNext = 1'b1;
                    memWeNext  = !reqQ.isLoad;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        readyNext = (stateNext == IDLE);
    end

    // State, captured request and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            reqQ           <= '0;
            cnt            <= '0;
            bus.ready_in   <= 1'b1;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.load_data  <= '0;
            bus.done       <= 1'b0;
            bus.wb_en      <= 1'b0;
            bus.fault      <= 1'b0;
            bus.fault_code <= FAULT_NONE;
        end else begin
            state          <= stateNext;
            reqQ           <= reqNext;
            cnt            <= cntNext;
            bus.ready_in   <= readyNext;
            bus.mem_req    <= memReqNext;
            bus.mem_we     <= memWeNext;
            bus.mem_addr   <= memAddrNext;
            bus.mem_wdata  <= memWdataNext;
            bus.load_data  <= loadDataNext;
            bus.done       <= doneNext;
            bus.wb_en      <= wbEnNext;
            bus.fault      <= faultNext;
            bus.fault_code <= faultCodeNext;
        end
    end

endmodule

// File: tb/tb_ldst_ctrl.sv
// Bench for ldst_ctrl: directed transactions plus randomized ones, checked
// cycle by cycle against an outcome model of each transaction.
module tb_ldst_ctrl;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset;
    int   nCmp = 0;
    int   nErr = 0;
    logic [63:0] lastLoad;

    ldst_ctrl_if bus ();

    ldst_ctrl #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input string tag,
                       input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s/%s observed=0x%h expected=0x%h", name, tag, obs, exp);
        end
    endtask

    // Effective address as plain signed arithmetic on the byte offset.
    function automatic logic [63:0] expAddr(input logic [63:0] b, input logic [8:0] im);
        longint off;
        off = (im < 9'd256) ? longint'(im) : longint'(im) - 64'sd512;
        return b + 64'(off);
    endfunction

    // One transaction; k = number of REQ cycles with mem_ready low before it rises.
    task automatic runTxn(input string name, input logic ld, input logic [63:0] b,
                          input logic [8:0] im, input logic [63:0] sd, input int k,
                          input logic busyPulse);
        logic [63:0] addr;
        logic [63:0] rdata;
        logic        mis, tmo, ok;
        logic [1:0]  code;
        int          reqLen, doneAt;
        bit          inReq;

        addr   = expAddr(b, im);
        mis    = (addr % 64'd8) != 64'd0;
        tmo    = !mis && (k >= TMO);
        ok     = !mis && !tmo;
        code   = mis ? 2'b01 : (tmo ? 2'b10 : 2'b00);
        reqLen = mis ? 0 : (tmo ? TMO : k + 1);
        doneAt = 2 + reqLen;
        rdata  = {$urandom, $urandom};

        chk(name, "ready_in_idle", 64'(bus.ready_in), 64'd1);
        bus.start      = 1'b1;
        bus.is_load    = ld;
        bus.base       = b;
        bus.imm9       = im;
        bus.store_data = sd;
        tick();
        // Inputs change after accept; a held start here must be ignored.
        bus.start      = busyPulse;
        bus.is_load    = ~ld;
        bus.base       = {$urandom, $urandom};
        bus.imm9       = 9'($urandom);
        bus.store_data = {$urandom, $urandom};

        for (int c = 1; c <= doneAt; c++) begin
            if (c == 2) bus.start = 1'b0;
            inReq = (c >= 2) && (c < 2 + reqLen);
            if (inReq) begin
                bus.mem_ready = (c - 2 >= k);
                bus.mem_rdata = bus.mem_ready ? rdata : {$urandom, $urandom};
            end else begin
                bus.mem_ready = 1'($urandom);
                bus.mem_rdata = {$urandom, $urandom};
            end
            chk(name, "mem_req", 64'(bus.mem_req), 64'(inReq));
            chk(name, "done", 64'(bus.done), 64'(c == doneAt));
            chk(name, "ready_in_busy", 64'(bus.ready_in), 64'd0);
            if (inReq) begin
                chk(name, "mem_addr", bus.mem_addr, addr);
                chk(name, "mem_we", 64'(bus.mem_we), 64'(!ld));
                if (!ld) chk(name, "mem_wdata", bus.mem_wdata, sd);
            end
            if (c == doneAt) begin
                if (ld && ok) lastLoad = rdata;
                chk(name, "fault", 64'(bus.fault), 64'(!ok));
                chk(name, "fault_code", 64'(bus.fault_code), 64'(code));
                chk(name, "wb_en", 64'(bus.wb_en), 64'(ld && ok));
                chk(name, "addr_done", bus.mem_addr, addr);
                chk(name, "load_data", bus.load_data, lastLoad);
            end
            tick();
        end

        chk(name, "done_after", 64'(bus.done), 64'd0);
        chk(name, "wb_en_after", 64'(bus.wb_en), 64'd0);
        chk(name, "mem_req_after", 64'(bus.mem_req), 64'd0);
        chk(name, "fault_hold", 64'(bus.fault_code), 64'(code));
        chk(name, "load_hold", bus.load_data, lastLoad);
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.is_load    = 1'b0;
        bus.base       = '0;
        bus.imm9       = '0;
        bus.store_data = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        lastLoad       = '0;

        repeat (2) tick();
        chk("reset", "ready_in", 64'(bus.ready_in), 64'd1);
        chk("reset", "mem_req", 64'(bus.mem_req), 64'd0);
        chk("reset", "mem_we", 64'(bus.mem_we), 64'd0);
        chk("reset", "done", 64'(bus.done), 64'd0);
        chk("reset", "wb_en", 64'(bus.wb_en), 64'd0);
        chk("reset", "fault", 64'(bus.fault), 64'd0);
        chk("reset", "fault_code", 64'(bus.fault_code), 64'd0);
        chk("reset", "mem_addr", bus.mem_addr, 64'd0);
        chk("reset", "mem_wdata", bus.mem_wdata, 64'd0);
        chk("reset", "load_data", bus.load_data, 64'd0);
        reset = 1'b0;
        tick();

        // Directed transactions.
        runTxn("load_fast", 1'b1, 64'h1000, 9'd16, 64'h0, 0, 1'b1);
        runTxn("store_slow", 1'b0, 64'h2000, 9'h1F8, 64'hDEAD_BEEF_CAFE_F00D, 3, 1'b0);
        runTxn("misalign", 1'b1, 64'h1003, 9'd0, 64'h0, 0, 1'b0);
        runTxn("timeout_held", 1'b1, 64'h4000, 9'd8, 64'h0, 50, 1'b0);
        runTxn("timeout_edge", 1'b0, 64'h4008, 9'd0, 64'h1234, 4, 1'b1);
        runTxn("wrap", 1'b1, 64'h0, 9'h1F8, 64'h0, 1, 1'b0);
        runTxn("after_busy", 1'b1, 64'h8000, 9'h100, 64'h0, 2, 1'b0);

        // Reset while waiting in REQ aborts the transaction silently.
        bus.start   = 1'b1;
        bus.is_load = 1'b1;
        bus.base    = 64'h3000;
        bus.imm9    = 9'd0;
        tick();
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        chk("rst_mid", "mem_req_in_req", 64'(bus.mem_req), 64'd1);
        reset = 1'b1;
        tick();
        chk("rst_mid", "mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_mid", "done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        tick();
        chk("rst_mid", "ready_in", 64'(bus.ready_in), 64'd1);
        chk("rst_mid", "load_data", bus.load_data, 64'd0);
        lastLoad = '0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid", "no_done", 64'(bus.done), 64'd0);
            tick();
        end

        // Randomized transactions, mostly aligned.
        for (int n = 0; n < 40; n++) begin
            logic [63:0] b;
            logic [63:0] a;
            logic [8:0]  im;
            b  = {$urandom, $urandom};
            im = 9'($urandom);
            a  = expAddr(b, im);
            if ($urandom_range(3) != 0) b = b - (a % 64'd8);
            runTxn("rnd", 1'($urandom), b, im, {$urandom, $urandom},
                   int'($urandom_range(6)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
